// File: rtl/simd_adder_rr_scheduler.sv
// Round-robin front end for one shared 2-cycle 4-lane SIMD adder: grants one
// requester per arbitration cycle, issues to the adder, and returns ID-tagged results in issue order.
module simd_adder_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int W      = 44,
    parameter int IDW    = 2,
    parameter int RDEPTH = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_ce,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              add_start,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic              add_ready,
    input  logic              add_done,
    input  logic [W-1:0]      add_z,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    input  logic              rsp_ready,
    output logic [2:0]        inflight,
    output logic              err
);
    localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int CW = $clog2(RDEPTH + 1);

    typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]     inflight_q, inflight_d;
    logic [IDW-1:0] tag_q [2];
    logic [IDW-1:0] tag_d [2];
    logic           err_q, err_d;
    logic [W-1:0]   dmem_q [RDEPTH];
    logic [W-1:0]   dmem_d [RDEPTH];
    logic [IDW-1:0] imem_q [RDEPTH];
    logic [IDW-1:0] imem_d [RDEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           found, credit_ok, accept, issue, done_ok, push, pop;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   sel_a, sel_b;

    // Cyclic search: first pass covers IDs at/after rr_ptr, second pass wraps below it.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && IDW'(i) >= rr_ptr_q) begin
                found = 1'b1; grant_id = IDW'(i);
                sel_a = req_a[i*W +: W]; sel_b = req_b[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && IDW'(i) < rr_ptr_q) begin
                found = 1'b1; grant_id = IDW'(i);
                sel_a = req_a[i*W +: W]; sel_b = req_b[i*W +: W];
            end
        end
    end

    // Ops in the adder plus results already queued may never exceed FIFO depth.
    assign credit_ok = (int'(inflight_q) + int'(cnt_q)) < RDEPTH;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)     state_q <= ARB;
        else if (ap_ce) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:   if (accept) state_d = ISSUE;
            ISSUE: if (issue)  state_d = ARB;
            default:           state_d = ARB;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        issue     = 1'b0;
        add_start = 1'b0;
        req_ready = '0;
        if (ap_ce) begin
            unique case (state_q)
                ARB: begin
                    accept    = found && credit_ok;
                    req_ready = accept ? (NREQ'(1) << grant_id) : '0;
                end
                ISSUE: begin
                    add_start = 1'b1;
                    issue     = add_ready;
                end
                default: ;
            endcase
        end
    end

    assign done_ok = add_done && (inflight_q != 3'd0);
    assign push    = done_ok;
    assign pop     = rsp_valid && rsp_ready;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        inflight_d = inflight_q;
        err_d      = err_q || (add_done && inflight_q == 3'd0);
        dmem_d     = dmem_q;
        imem_d     = imem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        tag_d[0]   = issue ? id_q : '0;
        tag_d[1]   = tag_q[0];
        if (accept) begin
            id_d     = grant_id;
            a_d      = sel_a;
            b_d      = sel_b;
            rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
        unique case ({issue, done_ok})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
        if (push) begin
            dmem_d[wr_ptr_q] = add_z;
            imem_d[wr_ptr_q] = tag_q[1];
            wr_ptr_d = (wr_ptr_q == PW'(RDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(RDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr_q   <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            inflight_q <= '0;
            tag_q      <= '{default: '0};
            err_q      <= 1'b0;
            dmem_q     <= '{default: '0};
            imem_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else if (ap_ce) begin
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            dmem_q     <= dmem_d;
            imem_q     <= imem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign inflight  = inflight_q;
    assign err       = err_q;
    assign rsp_valid = (cnt_q != '0);
    assign rsp_id    = rsp_valid ? imem_q[rd_ptr_q] : '0;
    assign rsp_data  = rsp_valid ? dmem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_simd_adder_rr_scheduler.sv
// Directed bench for simd_adder_rr_scheduler with a behavioural 2-cycle lane adder
// that shares the scheduler's clock enable and reset.
module tb_simd_adder_rr_scheduler;
    localparam int NREQ = 4, W = 44, IDW = 2, RDEPTH = 4;

    logic              ap_clk = 0, ap_rst = 1, ap_ce = 1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0, req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              add_start, add_ready = 1, add_done;
    logic [W-1:0]      add_a, add_b, add_z, rsp_data;
    logic              rsp_valid, rsp_ready = 1, err;
    logic [IDW-1:0]    rsp_id;
    logic [2:0]        inflight;
    logic              force_done = 0;

    simd_adder_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW), .RDEPTH(RDEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_ready(add_ready), .add_done(add_done), .add_z(add_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .inflight(inflight), .err(err));

    always #5 ap_clk = ~ap_clk;

    // Behavioural adder: per-lane 11-bit wrap, no carry across lanes.
    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] z;
        for (int l = 0; l < 4; l++) z[l*11 +: 11] = a[l*11 +: 11] + b[l*11 +: 11];
        return z;
    endfunction

    logic         s1_v = 0, s2_v = 0;
    logic [W-1:0] s1_z = '0, s2_z = '0;
    always @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_v <= 0; s2_v <= 0;
        end else if (ap_ce) begin
            s1_v <= add_start && add_ready; s1_z <= lane_add(add_a, add_b);
            s2_v <= s1_v; s2_z <= s1_z;
        end
    end
    assign add_done = s2_v || force_done;
    assign add_z    = s2_z;

    // Event log: grants and popped responses, stamped with cycle number.
    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;
    int           g_id[$], g_cyc[$], r_id[$], r_cyc[$];
    logic [W-1:0] r_data[$];
    always @(negedge ap_clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
        if (rsp_valid && rsp_ready && ap_ce) begin
            r_id.push_back(int'(rsp_id)); r_data.push_back(rsp_data); r_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk); #1;
    endtask

    task automatic wait_g(input int n, input string nm);
        int t = 0;
        while (g_id.size() < n && t < 60) begin tick(); t++; end
        chk({nm, "_grant_timeout"}, 64'(g_id.size() >= n), 64'd1);
    endtask

    task automatic wait_r(input int n, input string nm);
        int t = 0;
        while (r_id.size() < n && t < 60) begin tick(); t++; end
        chk({nm, "_rsp_timeout"}, 64'(r_id.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        ap_rst = 1; tick(); tick(); ap_rst = 0;
    endtask

    typedef struct {
        logic [W-1:0] a, b, z;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [W-1:0] ln(input logic [10:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [10:0] l = 11'(v);
        return {l, l, l, l};
    endfunction

    initial begin
        int gb, rb;
        vecs[0] = '{ln(4, 3, 2, 1), ln(40, 30, 20, 10), ln(44, 33, 22, 11)};
        vecs[1] = '{rep(11'h7FF), rep(11'h001), 44'h0};
        vecs[2] = '{ln(11'h7FF, 0, 11'h400, 11'h123), ln(11'h7FF, 0, 11'h400, 11'h0DC),
                    ln(11'h7FE, 0, 0, 11'h1FF)};
        vecs[3] = '{ln(1, 2, 3, 4), ln(11'h7FE, 11'h7FD, 0, 11'h010), ln(11'h7FF, 11'h7FF, 3, 11'h014)};

        do_reset();
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_add_start", 64'(add_start), 0);
        chk("rst_add_a", 64'(add_a), 0);
        chk("rst_add_b", 64'(add_b), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_id", 64'(rsp_id), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_inflight", 64'(inflight), 0);
        chk("rst_err", 64'(err), 0);

        // Table: single requester 0, one op at a time.
        for (int v = 0; v < 4; v++) begin
            gb = g_id.size(); rb = r_id.size();
            req_a[0 +: W] = vecs[v].a; req_b[0 +: W] = vecs[v].b; req_valid = 4'b0001;
            wait_g(gb + 1, $sformatf("vec%0d", v));
            req_valid = '0;
            wait_r(rb + 1, $sformatf("vec%0d", v));
            if (r_id.size() > rb && g_id.size() > gb) begin
                chk($sformatf("vec%0d_latency", v), 64'(r_cyc[rb] - g_cyc[gb]), 64'd4);
                chk($sformatf("vec%0d_data", v), 64'(r_data[rb]), 64'(vecs[v].z));
                chk($sformatf("vec%0d_id", v), 64'(r_id[rb]), 64'd0);
            end
        end

        // All four requesters valid straight out of reset.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = rep(i + 1); req_b[i*W +: W] = rep(100);
        end
        do_reset();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_g(k + 1, "rr4");
            if (g_id.size() > k) req_valid[g_id[k]] = 1'b0;
        end
        req_valid = '0;
        wait_r(4, "rr4");
        for (int k = 0; k < 4; k++) begin
            if (g_id.size() > k) chk($sformatf("rr4_grant%0d", k), 64'(g_id[k]), 64'(k));
            if (k > 0 && g_id.size() > k)
                chk($sformatf("rr4_gap%0d", k), 64'(g_cyc[k] - g_cyc[k-1]), 64'd2);
            if (r_id.size() > k) begin
                chk($sformatf("rr4_rsp_id%0d", k), 64'(r_id[k]), 64'(k));
                chk($sformatf("rr4_rsp_data%0d", k), 64'(r_data[k]), 64'(rep(k + 101)));
            end
        end

        // Credit limit: consumer stalled, six ops wanted.
        do_reset();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
        rsp_ready = 0; req_valid = 4'hF;
        wait_g(4, "credit");
        repeat (12) tick();
        chk("credit_stall_grants", 64'(g_id.size()), 64'd4);
        chk("credit_stall_req_ready", 64'(req_ready), 64'd0);
        chk("credit_stall_inflight", 64'(inflight), 64'd0);
        chk("credit_stall_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1;
        begin
            int t = 0;
            while ((g_id.size() < 6 || r_id.size() < 6) && t < 80) begin
                if (g_id.size() >= 6) req_valid = '0;
                tick(); t++;
            end
            chk("credit_drain_timeout", 64'(r_id.size() >= 6), 64'd1);
        end
        req_valid = '0;
        if (g_id.size() >= 6) begin
            chk("credit_grant4", 64'(g_id[4]), 64'd0);
            chk("credit_grant5", 64'(g_id[5]), 64'd1);
        end
        for (int k = 0; k < 6 && k < r_id.size(); k++) begin
            chk($sformatf("credit_rsp_id%0d", k), 64'(r_id[k]), 64'(k % 4));
            chk($sformatf("credit_rsp_data%0d", k), 64'(r_data[k]), 64'(rep(k % 4 + 101)));
        end

        // Adder back-pressure: ISSUE holds start and operands until add_ready.
        gb = g_id.size(); rb = r_id.size();
        req_a[1*W +: W] = vecs[0].a; req_b[1*W +: W] = vecs[0].b;
        add_ready = 0; req_valid = 4'b0010;
        wait_g(gb + 1, "stall");
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_add_start%0d", k), 64'(add_start), 64'd1);
            chk($sformatf("stall_add_a%0d", k), 64'(add_a), 64'(vecs[0].a));
            chk($sformatf("stall_inflight%0d", k), 64'(inflight), 64'd0);
            tick();
        end
        add_ready = 1;
        wait_r(rb + 1, "stall");
        if (r_id.size() > rb) begin
            chk("stall_rsp_data", 64'(r_data[rb]), 64'(vecs[0].z));
            chk("stall_rsp_id", 64'(r_id[rb]), 64'd1);
        end

        // Clock enable low for three cycles with one op inside the adder.
        req_a[1*W +: W] = rep(2); req_b[1*W +: W] = rep(100);
        gb = g_id.size(); rb = r_id.size();
        req_valid = 4'b1100;
        wait_g(gb + 1, "ce");
        if (g_id.size() > gb) begin
            chk("ce_first_grant", 64'(g_id[gb]), 64'd2);
            req_valid[2] = 1'b0;
        end
        tick();
        ap_ce = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ce_req_ready%0d", k), 64'(req_ready), 64'd0);
            chk($sformatf("ce_add_start%0d", k), 64'(add_start), 64'd0);
            chk($sformatf("ce_inflight%0d", k), 64'(inflight), 64'd1);
            chk($sformatf("ce_rsp_valid%0d", k), 64'(rsp_valid), 64'd0);
            tick();
        end
        ap_ce = 1;
        wait_g(gb + 2, "ce");
        req_valid = '0;
        wait_r(rb + 2, "ce");
        if (r_id.size() > rb + 1) begin
            chk("ce_rsp_id0", 64'(r_id[rb]), 64'd2);
            chk("ce_rsp_data0", 64'(r_data[rb]), 64'(rep(103)));
            chk("ce_rsp_id1", 64'(r_id[rb+1]), 64'd3);
            chk("ce_rsp_data1", 64'(r_data[rb+1]), 64'(rep(104)));
        end

        // Reset with one result queued and one op in the adder.
        gb = g_id.size();
        rsp_ready = 0; req_valid = 4'b0001;
        wait_g(gb + 2, "rstfly");
        req_valid = '0;
        tick();
        chk("rstfly_pre_inflight", 64'(inflight), 64'd1);
        chk("rstfly_pre_rsp_valid", 64'(rsp_valid), 64'd1);
        ap_rst = 1; tick(); ap_rst = 0;
        chk("rstfly_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstfly_inflight", 64'(inflight), 64'd0);
        rb = r_id.size();
        rsp_ready = 1;
        repeat (8) tick();
        chk("rstfly_no_stale", 64'(r_id.size() - rb), 64'd0);
        chk("rstfly_err", 64'(err), 64'd0);

        // Spurious add_done with nothing in flight.
        force_done = 1; tick(); force_done = 0;
        chk("err_set", 64'(err), 64'd1);
        chk("err_no_push", 64'(rsp_valid), 64'd0);
        chk("err_inflight", 64'(inflight), 64'd0);
        repeat (5) tick();
        chk("err_sticky", 64'(err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
